ge_eval_ctrl: RTL and testbench
===============================

# ge_eval_ctrl

Sequential front-end that shares the single combinational game-evaluation datapath (45-bit record in, `pass3` out) between two requesters. It arbitrates round-robin, holds the granted record stable on the evaluator inputs, captures the verdict, and returns it over a valid/ready response channel. It also keeps running pass/total statistics. It sits between the stimulus/record sources and the evaluator instance.

## Interface
- `REC_W`, 45: record width; fixed by the evaluator field map.
- `CNT_W`, 16: statistics counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: requester has a record.
- `req0_ready`, `req1_ready` out 1: record accepted on this edge when valid&ready.
- `req0_data`, `req1_data` in REC_W: record {speed[6:0], random1[6:0], breakfast[1:0], movement[1:0], weather, effort[6:0], hard[4:0], random2[4:0], slide[2:0], timing[2:0], luck3[2:0]}, MSB first.
- `eval_in` out REC_W: drives the evaluator inputs.
- `eval_pass` in 1: evaluator `pass3`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester index of the response.
- `rsp_pass` out 1: captured verdict.
- `clr` in 1: synchronous statistics clear.
- `total_cnt`, `pass_cnt` out CNT_W: responses delivered / responses with pass=1.

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE: `reqN_ready` = 1 only for the arbiter's grant (at most one ready high). If no requester is valid, stay in IDLE. On handshake, latch data into `eval_reg` and the grant into `id_reg`, then go to EVAL.
- EVAL: `eval_in` = `eval_reg`, held stable. Both readies are 0. At the end of the cycle, capture `eval_pass` into `pass_reg`, then go to RESP.
- RESP: `rsp_valid` = 1; `rsp_id`/`rsp_pass` stay stable until `rsp_ready`. On `rsp_valid & rsp_ready`, go to IDLE and update counters.
- Arbitration: 2-way round-robin on `last_grant`. With both requesters valid, grant the one not last granted. With one valid, grant it. `last_grant` updates only on a request handshake.
- `eval_in` holds its last value outside EVAL; its reset value is 0.
- Counters: `total_cnt` +1 per response handshake; `pass_cnt` +1 when `rsp_pass` is also 1. Both saturate at all-ones. `clr` zeroes both and wins over a same-cycle increment.
- Reset mid-operation drops any in-flight record; no response is produced for it.

## Timing
- Reset values: `req0_ready`=`req1_ready`=0 during reset, state=IDLE, `last_grant`=1 (req0 wins the first tie), `eval_in`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_pass`=0, all counters 0.
- Request handshake at edge N. `eval_in` is valid after N. The verdict is captured at N+1, and `rsp_valid` is high after N+1.
- Minimum period is 3 cycles per record. The next request handshake can occur no earlier than the edge after the response handshake.
- Readies are combinational from state and `reqN_valid`. There is no combinational path from `rsp_ready` to `reqN_ready`.
- Counters are visible the cycle after the response handshake.

## Configuration
- `GE_CHECK_EN` defined:
  - Adds inputs `req0_exp`, `req1_exp` (1 bit each), latched with the record.
  - Adds output `rsp_mismatch` = `pass_reg` != `exp_reg`, valid with `rsp_valid`.
  - Adds output `mismatch_cnt` (CNT_W): +1 per response handshake with mismatch, saturating, cleared by `clr`/`rst`.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

## Structure
- Package `ge_pkg` holds:
  - `REC_W`, the field offset/width localparams for the record map.
  - The state enum {IDLE, EVAL, RESP}.
  - The default `CNT_W`.
- Sub-module `ge_rr_arb`: 2-requester round-robin arbiter (inputs valid[1:0], advance; outputs grant one-hot, with the `last_grant` register inside).
- The evaluator is instantiated outside this block.

## Test plan
- Reset then single req0 record 45'h0 with `eval_pass` tied 1, `rsp_ready`=1: `req0_ready` is high in the first IDLE cycle; `rsp_valid` at cycle +2 with `rsp_id`=0, `rsp_pass`=1; then `total_cnt`=1, `pass_cnt`=1.
- Both requesters continuously valid for 6 records: grant order 0,1,0,1,0,1; never both readies high.
- Hold `rsp_ready`=0 for 5 cycles in RESP: `rsp_valid`/`rsp_id`/`rsp_pass` are stable, readies stay 0, counters are unchanged.
- Preload counters to 16'hFFFF via 65535 pass responses, then one more pass: both stay at FFFF. Assert `clr` in the same cycle as a response handshake: both read 0.
- Assert `rst` during EVAL: outputs return to reset values at once, and no `rsp_valid` follows for the dropped record.
- With `GE_CHECK_EN`: 20 random records fed to the real evaluator with correct `exp`, plus 3 with inverted `exp`: `mismatch_cnt`=3 and `rsp_mismatch` is high exactly on those 3.

Source files
------------

// File: rtl/ge_pkg.sv
// Shared definitions for the game-evaluation front-end: record field map,
// controller state encoding and default statistics width.
package ge_pkg;

    localparam int REC_W     = 45;
    localparam int CNT_W_DEF = 16;

    // Record field map, LSB offsets and widths (speed is the MSB field)
    localparam int LUCK3_LSB     = 0;
    localparam int LUCK3_W       = 3;
    localparam int TIMING_LSB    = 3;
    localparam int TIMING_W      = 3;
    localparam int SLIDE_LSB     = 6;
    localparam int SLIDE_W       = 3;
    localparam int RANDOM2_LSB   = 9;
    localparam int RANDOM2_W     = 5;
    localparam int HARD_LSB      = 14;
    localparam int HARD_W        = 5;
    localparam int EFFORT_LSB    = 19;
    localparam int EFFORT_W      = 7;
    localparam int WEATHER_LSB   = 26;
    localparam int WEATHER_W     = 1;
    localparam int MOVEMENT_LSB  = 27;
    localparam int MOVEMENT_W    = 2;
    localparam int BREAKFAST_LSB = 29;
    localparam int BREAKFAST_W   = 2;
    localparam int RANDOM1_LSB   = 31;
    localparam int RANDOM1_W     = 7;
    localparam int SPEED_LSB     = 38;
    localparam int SPEED_W       = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } ge_state_e;

endpackage

// File: rtl/ge_rr_arb.sv
// Two-requester round-robin arbiter; the last-grant pointer moves only when
// the caller reports that the current grant was consumed.
module ge_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and pointer update
    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (advance) begin
            last_grant_d = grant[1];
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Reset value 1 lets requester 0 win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ge_eval_ctrl.sv
// Shares one combinational game evaluator between two requesters and returns
// verdicts over a valid/ready channel. Optional GE_CHECK_EN adds expected-verdict checking.
module ge_eval_ctrl
    import ge_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [REC_W-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [REC_W-1:0] req1_data,
    output logic [REC_W-1:0] eval_in,
    input  logic             eval_pass,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_pass,
`ifdef GE_CHECK_EN
    input  logic             req0_exp,
    input  logic             req1_exp,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] mismatch_cnt,
`endif
    input  logic             clr,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] pass_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ge_state_e        state_q, state_d;
    logic [REC_W-1:0] eval_q, eval_d;
    logic             id_q, id_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]       grant;
    logic             advance;
    logic             rsp_hs;

    ge_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (advance),
        .grant   (grant)
    );

    // Next-state, capture and statistics logic
    always_comb begin
        state_d = state_q;
        eval_d  = eval_q;
        id_d    = id_q;
        pass_d  = pass_q;
        total_d = total_q;
        pcnt_d  = pcnt_q;
        advance = 1'b0;
        rsp_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    advance = 1'b1;
                    eval_d  = grant[1] ? req1_data : req0_data;
                    id_d    = grant[1];
                    state_d = EVAL;
                end else begin
                    state_d = IDLE;
                end
            end
            EVAL: begin
                pass_d  = eval_pass;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear takes priority over a coincident response
        if (clr) begin
            total_d = {CNT_W{1'b0}};
            pcnt_d  = {CNT_W{1'b0}};
        end else if (rsp_hs) begin
            total_d = (total_q == CNT_MAX) ? total_q : total_q + CNT_ONE;
            pcnt_d  = (pass_q && (pcnt_q != CNT_MAX)) ? pcnt_q + CNT_ONE : pcnt_q;
        end else begin
            total_d = total_q;
            pcnt_d  = pcnt_q;
        end
    end

    // Controller state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            eval_q  <= {REC_W{1'b0}};
            id_q    <= 1'b0;
            pass_q  <= 1'b0;
            total_q <= {CNT_W{1'b0}};
            pcnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            eval_q  <= eval_d;
            id_q    <= id_d;
            pass_q  <= pass_d;
            total_q <= total_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign req0_ready = (state_q == IDLE) & grant[0] & ~rst;
    assign req1_ready = (state_q == IDLE) & grant[1] & ~rst;
    assign eval_in    = eval_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_pass   = pass_q;
    assign total_cnt  = total_q;
    assign pass_cnt   = pcnt_q;

`ifdef GE_CHECK_EN
    logic             exp_q, exp_d;
    logic [CNT_W-1:0] mis_q, mis_d;

    // Expected verdict latched with the record; mismatch statistics
    always_comb begin
        exp_d = exp_q;
        mis_d = mis_q;
        if (advance) begin
            exp_d = grant[1] ? req1_exp : req0_exp;
        end else begin
            exp_d = exp_q;
        end
        if (clr) begin
            mis_d = {CNT_W{1'b0}};
        end else if (rsp_hs && (pass_q != exp_q) && (mis_q != CNT_MAX)) begin
            mis_d = mis_q + CNT_ONE;
        end else begin
            mis_d = mis_q;
        end
    end

    // Check-path registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= 1'b0;
            mis_q <= {CNT_W{1'b0}};
        end else begin
            exp_q <= exp_d;
            mis_q <= mis_d;
        end
    end

    assign rsp_mismatch = rsp_valid & (pass_q != exp_q);
    assign mismatch_cnt = mis_q;
`endif

endmodule

// File: tb/tb_ge_eval_ctrl.sv
// Directed bench for ge_eval_ctrl; counters use a narrow width so saturation is reachable.
module tb_ge_eval_ctrl;
    import ge_pkg::*;

    localparam int CW = 8;
    localparam logic [REC_W-1:0] D0 = 45'h0A5A_5A5A_5A5A;
    localparam logic [REC_W-1:0] D1 = 45'h1555_0F0F_3C3C;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [REC_W-1:0] req0_data = '0, req1_data = '0;
    logic [REC_W-1:0] eval_in;
    logic             eval_pass = 1'b0;
    logic             rsp_valid, rsp_id, rsp_pass;
    logic             rsp_ready = 1'b0;
    logic             clr = 1'b0;
    logic [CW-1:0]    total_cnt, pass_cnt;
`ifdef GE_CHECK_EN
    logic             req0_exp = 1'b0, req1_exp = 1'b0;
    logic             rsp_mismatch;
    logic [CW-1:0]    mismatch_cnt;
`endif

    int total_n = 0;
    int bad_n   = 0;

    ge_eval_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .eval_in(eval_in), .eval_pass(eval_pass),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_pass(rsp_pass),
`ifdef GE_CHECK_EN
        .req0_exp(req0_exp), .req1_exp(req1_exp),
        .rsp_mismatch(rsp_mismatch), .mismatch_cnt(mismatch_cnt),
`endif
        .clr(clr), .total_cnt(total_cnt), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic reset_dut;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b0; clr = 1'b0; eval_pass = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for either ready; who = -1 on timeout
    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin who = 0; break; end
            if (req1_ready) begin who = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        total_n++; if ({req0_ready, req1_ready} !== 2'b00) begin bad_n++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
        total_n++; if (eval_in !== '0) begin bad_n++; $display("FAIL reset_eval_in got=%h want=0", eval_in); end
        total_n++; if ({rsp_valid, rsp_id, rsp_pass} !== 3'b000) begin bad_n++; $display("FAIL reset_rsp got=%b want=000", {rsp_valid, rsp_id, rsp_pass}); end
        total_n++; if ({total_cnt, pass_cnt} !== '0) begin bad_n++; $display("FAIL reset_cnt got=%h/%h want=0/0", total_cnt, pass_cnt); end
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic test_single;
        eval_pass = 1'b1; rsp_ready = 1'b1; req0_data = '0; req0_valid = 1'b1;
        #1;
        total_n++; if ({req0_ready, req1_ready} !== 2'b10) begin bad_n++; $display("FAIL single_ready got=%b want=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        total_n++; if ({rsp_valid, req0_ready} !== 2'b00) begin bad_n++; $display("FAIL single_eval got=%b want=00", {rsp_valid, req0_ready}); end
        @(negedge clk);
        total_n++; if ({rsp_valid, rsp_id, rsp_pass} !== 3'b101) begin bad_n++; $display("FAIL single_rsp got=%b want=101", {rsp_valid, rsp_id, rsp_pass}); end
        @(negedge clk);
        total_n++; if (rsp_valid !== 1'b0) begin bad_n++; $display("FAIL single_rsp_drop got=%b want=0", rsp_valid); end
        total_n++; if ({total_cnt, pass_cnt} !== {8'd1, 8'd1}) begin bad_n++; $display("FAIL single_cnt got=%0d/%0d want=1/1", total_cnt, pass_cnt); end
    endtask

    task automatic test_round_robin;
        int who;
        logic ep;
        reset_dut();
        rsp_ready = 1'b1; req0_data = D0; req1_data = D1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ep = (k % 3 == 0);
            wait_grant(who);
            total_n++; if (who != k % 2) begin bad_n++; $display("FAIL rr_grant k=%0d got=%0d want=%0d", k, who, k % 2); end
            total_n++; if (req0_ready && req1_ready) begin bad_n++; $display("FAIL rr_both_ready got=11 want=one-hot"); end
            eval_pass = ep;
            @(negedge clk);
            total_n++; if (eval_in !== ((k % 2 == 1) ? D1 : D0)) begin bad_n++; $display("FAIL rr_eval_in k=%0d got=%h", k, eval_in); end
            total_n++; if ({req0_ready, req1_ready} !== 2'b00) begin bad_n++; $display("FAIL rr_eval_ready got=%b want=00", {req0_ready, req1_ready}); end
            @(negedge clk);
            total_n++; if ({rsp_valid, rsp_id, rsp_pass} !== {1'b1, k[0], ep}) begin bad_n++; $display("FAIL rr_rsp k=%0d got=%b want=%b", k, {rsp_valid, rsp_id, rsp_pass}, {1'b1, k[0], ep}); end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total_n++; if ({total_cnt, pass_cnt} !== {8'd6, 8'd2}) begin bad_n++; $display("FAIL rr_cnt got=%0d/%0d want=6/2", total_cnt, pass_cnt); end
    endtask

    task automatic test_stall;
        int who;
        reset_dut();
        eval_pass = 1'b0; rsp_ready = 1'b0; req1_data = D1; req1_valid = 1'b1;
        wait_grant(who);
        total_n++; if (who != 1) begin bad_n++; $display("FAIL stall_grant got=%0d want=1", who); end
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            total_n++; if ({rsp_valid, rsp_id, rsp_pass} !== 3'b110) begin bad_n++; $display("FAIL stall_rsp c=%0d got=%b want=110", c, {rsp_valid, rsp_id, rsp_pass}); end
            total_n++; if ({req0_ready, req1_ready} !== 2'b00) begin bad_n++; $display("FAIL stall_ready c=%0d got=%b want=00", c, {req0_ready, req1_ready}); end
            total_n++; if (total_cnt !== 8'd0) begin bad_n++; $display("FAIL stall_cnt c=%0d got=%0d want=0", c, total_cnt); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total_n++; if ({rsp_valid, total_cnt, pass_cnt} !== {1'b0, 8'd1, 8'd0}) begin bad_n++; $display("FAIL stall_release got=%b/%0d/%0d want=0/1/0", rsp_valid, total_cnt, pass_cnt); end
        total_n++; if (req0_ready !== 1'b1) begin bad_n++; $display("FAIL stall_next_ready got=%b want=1", req0_ready); end
        req0_valid = 1'b0;
    endtask

    task automatic test_saturate_clr;
        reset_dut();
        eval_pass = 1'b1; rsp_ready = 1'b1; req0_data = D0; req0_valid = 1'b1;
        repeat (3 * 255) @(negedge clk);
        total_n++; if ({total_cnt, pass_cnt} !== {8'hFF, 8'hFF}) begin bad_n++; $display("FAIL sat_reach got=%h/%h want=ff/ff", total_cnt, pass_cnt); end
        repeat (3) @(negedge clk);
        total_n++; if ({total_cnt, pass_cnt} !== {8'hFF, 8'hFF}) begin bad_n++; $display("FAIL sat_hold got=%h/%h want=ff/ff", total_cnt, pass_cnt); end
        repeat (2) @(negedge clk);
        total_n++; if (rsp_valid !== 1'b1) begin bad_n++; $display("FAIL clr_pre_rsp got=%b want=1", rsp_valid); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; req0_valid = 1'b0;
        total_n++; if ({total_cnt, pass_cnt} !== 16'h0000) begin bad_n++; $display("FAIL clr_wins got=%h/%h want=0/0", total_cnt, pass_cnt); end
    endtask

    task automatic test_reset_mid;
        int who;
        reset_dut();
        eval_pass = 1'b1; rsp_ready = 1'b1; req0_data = D0; req0_valid = 1'b1;
        wait_grant(who);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1;
        total_n++; if (eval_in !== D0) begin bad_n++; $display("FAIL mid_pre_eval got=%h want=%h", eval_in, D0); end
        rst = 1'b1;
        #1;
        total_n++; if (eval_in !== '0) begin bad_n++; $display("FAIL mid_eval_in got=%h want=0", eval_in); end
        total_n++; if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_pass} !== 5'b0) begin bad_n++; $display("FAIL mid_outputs got=%b want=00000", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_pass}); end
        @(negedge clk);
        rst = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total_n++; if (rsp_valid !== 1'b0) begin bad_n++; $display("FAIL mid_no_rsp c=%0d got=%b want=0", c, rsp_valid); end
        end
    endtask

`ifdef GE_CHECK_EN
    task automatic test_check;
        int who;
        logic ep, inv;
        reset_dut();
        rsp_ready = 1'b1; req0_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ep  = k[0];
            inv = (k == 2 || k == 5 || k == 7);
            req0_data = D0 ^ REC_W'(k);
            req0_exp  = ep ^ inv;
            eval_pass = ep;
            wait_grant(who);
            @(negedge clk);
            @(negedge clk);
            total_n++; if (rsp_mismatch !== inv) begin bad_n++; $display("FAIL chk_mismatch k=%0d got=%b want=%b", k, rsp_mismatch, inv); end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        total_n++; if (mismatch_cnt !== 8'd3) begin bad_n++; $display("FAIL chk_cnt got=%0d want=3", mismatch_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_saturate_clr();
        test_reset_mid();
`ifdef GE_CHECK_EN
        test_check();
`endif
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
